pipe_buf: RTL and testbench
===========================

# pipe_buf

Parametrised elastic pipeline buffer: the next generation of the fixed inter-stage registers (IF2ID … MEM2WB). It carries an arbitrary-width stage payload between two pipeline stages with valid/ready handshaking on both sides, a synchronous flush, and DEPTH-entry FIFO buffering. A DEPTH of 2 gives full throughput with no combinational ready path between stages.

## Interface
Parameters:
- DATA_W, default 32: payload width in bits (packed stage bundle: data plus control fields); ≥1.
- DEPTH, default 2: number of storage entries; ≥1; need not be a power of two.
- CNT_W, default $clog2(DEPTH+1): width of the occupancy count.

Ports:
- clk  in  1  clock, all state on posedge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid_i  in  1  upstream stage presents a payload.
- in_ready_o  out  1  buffer accepts a payload this cycle.
- in_data_i  in  DATA_W  upstream payload.
- out_valid_o  out  1  head entry valid.
- out_ready_i  in  1  downstream stage consumes the head.
- out_data_o  out  DATA_W  head payload.
- flush_i  in  1  discard all contents (branch mispredict / trap).
- count_o  out  CNT_W  current occupancy, 0..DEPTH.

## Operation
- State: storage array mem[0..DEPTH-1], write pointer wptr, read pointer rptr, occupancy cnt.
- push = in_valid_i & in_ready_o; pop = out_valid_o & out_ready_i.
- in_ready_o = (cnt != DEPTH), from registered state only; never a function of out_ready_i.
- out_valid_o = (cnt != 0); out_data_o = mem[rptr]. No bypass: a payload never appears at the output in the cycle it is pushed.
- On push: mem[wptr] <= in_data_i; wptr advances.
- On pop: rptr advances.
- Pointer advance: ptr == DEPTH-1 wraps to 0, otherwise ptr+1 (exact for non-power-of-two DEPTH).
- cnt: +1 on push only, −1 on pop only, unchanged on push and pop together.
- flush_i (synchronous) overrides everything: wptr, rptr and cnt go to 0, and the same-cycle push and pop are both discarded. mem contents are not cleared and are not observable, because out_valid_o is 0.
- Upstream may drop or change in_data_i while in_ready_o is low. Downstream must treat out_data_o as meaningful only while out_valid_o is 1.
- Overflow and underflow are impossible by construction: push is gated by in_ready_o and pop is gated by out_valid_o.

## Timing
- Reset (asynchronous assert, any cycle, including mid-transfer): wptr=0, rptr=0, cnt=0, all mem entries=0. Outputs: out_valid_o=0, out_data_o=0, in_ready_o=1, count_o=0.
- First clock edge after rst deasserts may push.
- Latency: payload pushed at edge N into an empty buffer gives out_valid_o=1 with that payload after edge N, so it is consumable in cycle N+1.
- Throughput: DEPTH≥2 sustains one transfer per cycle with out_ready_i held high. DEPTH=1 alternates push and pop, giving 1/2 throughput; this is intended, as the DEPTH=1 configuration acts as a stall-capable replacement for the plain stage register.
- Full (cnt=DEPTH): in_ready_o=0 even if out_ready_i=1 in that cycle. A pop frees space, and in_ready_o rises the following cycle.
- Empty with a same-cycle push: no pop occurs; cnt goes 0→1.
- flush_i with push in the same cycle: cnt=0 after the edge, and the payload is lost.
- count_o, in_ready_o and out_valid_o are mutually consistent every cycle.

## Test plan
- Reset mid-traffic: DEPTH=2, push 0xA, 0xB, then assert rst asynchronously between edges → out_valid_o=0, count_o=0, in_ready_o=1, out_data_o=0 immediately, with no clock edge needed.
- Streaming: DEPTH=2, out_ready_i=1, in_valid_i=1 for 8 cycles with data 1..8 → output 1..8 in order, one per cycle starting one cycle after the first push; count_o stays at 1.
- Backpressure and full: DEPTH=3, out_ready_i=0, push 0x11, 0x22, 0x33, 0x44 → in_ready_o=0 after the third push, 0x44 is held upstream, count_o=3. Raise out_ready_i for one cycle → 0x11 pops, in_ready_o=1 next cycle, 0x44 accepted; pop order is 0x22, 0x33, 0x44.
- Wrap-around, non-power-of-two: DEPTH=3, 10 random push/pop cycles with random valid/ready → scoreboard order is exact and count_o matches the model every cycle.
- Flush with simultaneous push and pop: DEPTH=2 holding 0x5, 0x6; in the same cycle in_valid_i=1 (0x7), out_ready_i=1, flush_i=1 → next cycle count_o=0 and out_valid_o=0. A subsequent push of 0x8 is the next output.
- DEPTH=1: out_ready_i=1, in_valid_i=1 constantly → in_ready_o toggles 1,0,1,0 and outputs appear every other cycle.

Source files
------------

// File: rtl/pipe_buf_if.sv
`default_nettype none
// ------------------------------------------------------------------
// pipe_buf_if : valid/ready stage-to-stage bundle for pipe_buf
// Revision    : 1.0
// ------------------------------------------------------------------
interface pipe_buf_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = $clog2(DEPTH + 1)
);
  logic              in_valid_i;
  logic              in_ready_o;
  logic [DATA_W-1:0] in_data_i;
  logic              out_valid_o;
  logic              out_ready_i;
  logic [DATA_W-1:0] out_data_o;
  logic              flush_i;
  logic [CNT_W-1:0]  count_o;

  // slave is the buffer itself; master is whatever surrounds it
  modport slave (
    input  in_valid_i, in_data_i, out_ready_i, flush_i,
    output in_ready_o, out_valid_o, out_data_o, count_o
  );

  modport master (
    output in_valid_i, in_data_i, out_ready_i, flush_i,
    input  in_ready_o, out_valid_o, out_data_o, count_o
  );
endinterface
`default_nettype wire

// File: rtl/pipe_buf.sv
`default_nettype none
// ------------------------------------------------------------------
// pipe_buf : elastic DEPTH-entry pipeline buffer with synchronous flush
// Revision : 1.0
// ------------------------------------------------------------------
module pipe_buf #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic      clk,
  input  logic      rst,
  pipe_buf_if.slave bus
);
  localparam int              PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              in_ready;
  logic              out_valid;
  logic              push;
  logic              pop;

  // Explicit wrap keeps non-power-of-two depths exact
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign in_ready  = (cnt_q != FULL_CNT);
  assign out_valid = (cnt_q != '0);
  assign push      = bus.in_valid_i & in_ready;
  assign pop       = out_valid & bus.out_ready_i;

  assign bus.in_ready_o  = in_ready;
  assign bus.out_valid_o = out_valid;
  assign bus.out_data_o  = mem_q[rptr_q];
  assign bus.count_o     = cnt_q;

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (bus.flush_i) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (push) begin
        mem_d[wptr_q] = bus.in_data_i;
        wptr_d        = ptr_next(wptr_q);
      end
      if (pop) begin
        rptr_d = ptr_next(rptr_q);
      end
      if (push && !pop) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else if (pop && !push) begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      mem_q  <= mem_d;
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_pipe_buf.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_pipe_buf : checks pipe_buf at DEPTH 1, 2 and 3 against a queue model
// Revision    : 1.0
// ------------------------------------------------------------------
module tb_pipe_buf;
  logic clk;
  logic rst;

  int checks;
  int failures;

  pipe_buf_if #(.DATA_W(32), .DEPTH(1)) if1 ();
  pipe_buf_if #(.DATA_W(32), .DEPTH(2)) if2 ();
  pipe_buf_if #(.DATA_W(32), .DEPTH(3)) if3 ();

  pipe_buf #(.DATA_W(32), .DEPTH(1)) u_d1 (.clk(clk), .rst(rst), .bus(if1));
  pipe_buf #(.DATA_W(32), .DEPTH(2)) u_d2 (.clk(clk), .rst(rst), .bus(if2));
  pipe_buf #(.DATA_W(32), .DEPTH(3)) u_d3 (.clk(clk), .rst(rst), .bus(if3));

  // Index k addresses the instance whose DEPTH is k
  logic        drv_v [1:3];
  logic [31:0] drv_d [1:3];
  logic        drv_r [1:3];
  logic        drv_f [1:3];
  logic        obs_v  [1:3];
  logic        obs_ir [1:3];
  logic [31:0] obs_d  [1:3];
  logic [31:0] obs_c  [1:3];

  assign if1.in_valid_i = drv_v[1];
  assign if1.in_data_i  = drv_d[1];
  assign if1.out_ready_i = drv_r[1];
  assign if1.flush_i    = drv_f[1];
  assign if2.in_valid_i = drv_v[2];
  assign if2.in_data_i  = drv_d[2];
  assign if2.out_ready_i = drv_r[2];
  assign if2.flush_i    = drv_f[2];
  assign if3.in_valid_i = drv_v[3];
  assign if3.in_data_i  = drv_d[3];
  assign if3.out_ready_i = drv_r[3];
  assign if3.flush_i    = drv_f[3];

  assign obs_v[1]  = if1.out_valid_o;
  assign obs_ir[1] = if1.in_ready_o;
  assign obs_d[1]  = if1.out_data_o;
  assign obs_c[1]  = 32'(if1.count_o);
  assign obs_v[2]  = if2.out_valid_o;
  assign obs_ir[2] = if2.in_ready_o;
  assign obs_d[2]  = if2.out_data_o;
  assign obs_c[2]  = 32'(if2.count_o);
  assign obs_v[3]  = if3.out_valid_o;
  assign obs_ir[3] = if3.in_ready_o;
  assign obs_d[3]  = if3.out_data_o;
  assign obs_c[3]  = 32'(if3.count_o);

  // Reference model: one FIFO queue per instance, capacity = index
  logic [31:0] mq1 [$];
  logic [31:0] mq2 [$];
  logic [31:0] mq3 [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int msize(input int d);
    case (d)
      1:       return mq1.size();
      2:       return mq2.size();
      default: return mq3.size();
    endcase
  endfunction

  function automatic logic [31:0] mhead(input int d);
    case (d)
      1:       return (mq1.size() != 0) ? mq1[0] : 32'h0;
      2:       return (mq2.size() != 0) ? mq2[0] : 32'h0;
      default: return (mq3.size() != 0) ? mq3[0] : 32'h0;
    endcase
  endfunction

  task automatic model_clear();
    mq1.delete();
    mq2.delete();
    mq3.delete();
  endtask

  // Drive one cycle on instance d; model updates from pre-edge occupancy
  task automatic drive_edge(input int d, input bit v, input logic [31:0] data,
                            input bit r, input bit f);
    bit do_push;
    bit do_pop;
    logic [31:0] junk;
    drv_v[d] = v;
    drv_d[d] = data;
    drv_r[d] = r;
    drv_f[d] = f;
    do_push = v && (msize(d) < d);
    do_pop  = r && (msize(d) > 0);
    if (f) begin
      case (d)
        1:       mq1.delete();
        2:       mq2.delete();
        default: mq3.delete();
      endcase
    end else begin
      if (do_pop) begin
        case (d)
          1:       junk = mq1.pop_front();
          2:       junk = mq2.pop_front();
          default: junk = mq3.pop_front();
        endcase
      end
      if (do_push) begin
        case (d)
          1:       mq1.push_back(data);
          2:       mq2.push_back(data);
          default: mq3.push_back(data);
        endcase
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int d = 1; d <= 3; d++) begin
      checks += 4;
      if (obs_v[d] !== 1'b0) begin
        failures++; $display("FAIL reset_valid d=%0d got=%b exp=0", d, obs_v[d]);
      end
      if (obs_c[d] !== 32'd0) begin
        failures++; $display("FAIL reset_count d=%0d got=%0d exp=0", d, obs_c[d]);
      end
      if (obs_ir[d] !== 1'b1) begin
        failures++; $display("FAIL reset_ready d=%0d got=%b exp=1", d, obs_ir[d]);
      end
      if (obs_d[d] !== 32'h0) begin
        failures++; $display("FAIL reset_data d=%0d got=%h exp=0", d, obs_d[d]);
      end
    end
    rst = 1'b0;
    model_clear();
    drive_edge(2, 1'b1, 32'hA, 1'b0, 1'b0);
    drive_edge(2, 1'b1, 32'hB, 1'b0, 1'b0);
    drv_v[2] = 1'b0;
    checks++;
    if (obs_c[2] !== 32'd2) begin
      failures++; $display("FAIL midreset_pre_count got=%0d exp=2", obs_c[2]);
    end
    #2 rst = 1'b1;
    #1;
    checks += 4;
    if (obs_v[2] !== 1'b0) begin
      failures++; $display("FAIL midreset_valid got=%b exp=0", obs_v[2]);
    end
    if (obs_c[2] !== 32'd0) begin
      failures++; $display("FAIL midreset_count got=%0d exp=0", obs_c[2]);
    end
    if (obs_ir[2] !== 1'b1) begin
      failures++; $display("FAIL midreset_ready got=%b exp=1", obs_ir[2]);
    end
    if (obs_d[2] !== 32'h0) begin
      failures++; $display("FAIL midreset_data got=%h exp=0", obs_d[2]);
    end
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  task automatic test_stream();
    logic [31:0] popped [$];
    for (int i = 0; i < 11; i++) begin
      checks += 3;
      if (obs_c[2] !== 32'(msize(2))) begin
        failures++; $display("FAIL stream_count cyc=%0d got=%0d exp=%0d", i, obs_c[2], msize(2));
      end
      if (obs_v[2] !== (msize(2) != 0)) begin
        failures++; $display("FAIL stream_valid cyc=%0d got=%b exp=%b", i, obs_v[2], msize(2) != 0);
      end
      if (obs_ir[2] !== (msize(2) != 2)) begin
        failures++; $display("FAIL stream_ready cyc=%0d got=%b exp=%b", i, obs_ir[2], msize(2) != 2);
      end
      if (i >= 1 && i <= 8) begin
        checks++;
        if (obs_c[2] !== 32'd1) begin
          failures++; $display("FAIL stream_steady_count cyc=%0d got=%0d exp=1", i, obs_c[2]);
        end
      end
      if (obs_v[2] === 1'b1) popped.push_back(obs_d[2]);
      drive_edge(2, i < 8, 32'(i + 1), 1'b1, 1'b0);
    end
    drv_v[2] = 1'b0;
    checks++;
    if (popped.size() != 8) begin
      failures++; $display("FAIL stream_len got=%0d exp=8", popped.size());
    end
    for (int k = 0; k < popped.size() && k < 8; k++) begin
      checks++;
      if (popped[k] !== 32'(k + 1)) begin
        failures++; $display("FAIL stream_order idx=%0d got=%h exp=%h", k, popped[k], k + 1);
      end
    end
  endtask

  task automatic test_backpressure();
    bit          sv [10] = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
    logic [31:0] sd [10] = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h44, 32'h44, 0, 0, 0, 0};
    bit          sr [10] = '{0, 0, 0, 0, 1, 0, 1, 1, 1, 1};
    logic [31:0] exp_pop [4] = '{32'h11, 32'h22, 32'h33, 32'h44};
    logic [31:0] popped [$];
    for (int i = 0; i < 10; i++) begin
      checks += 3;
      if (obs_c[3] !== 32'(msize(3))) begin
        failures++; $display("FAIL bp_count step=%0d got=%0d exp=%0d", i, obs_c[3], msize(3));
      end
      if (obs_ir[3] !== (msize(3) != 3)) begin
        failures++; $display("FAIL bp_ready step=%0d got=%b exp=%b", i, obs_ir[3], msize(3) != 3);
      end
      if (obs_v[3] === 1'b1 && obs_d[3] !== mhead(3)) begin
        failures++; $display("FAIL bp_head step=%0d got=%h exp=%h", i, obs_d[3], mhead(3));
      end
      if (i == 3 || i == 4) begin
        checks += 2;
        if (obs_ir[3] !== 1'b0) begin
          failures++; $display("FAIL bp_full_ready step=%0d got=%b exp=0", i, obs_ir[3]);
        end
        if (obs_c[3] !== 32'd3) begin
          failures++; $display("FAIL bp_full_count step=%0d got=%0d exp=3", i, obs_c[3]);
        end
      end
      if (i == 5) begin
        checks++;
        if (obs_ir[3] !== 1'b1) begin
          failures++; $display("FAIL bp_freed_ready got=%b exp=1", obs_ir[3]);
        end
      end
      if (obs_v[3] === 1'b1 && sr[i]) popped.push_back(obs_d[3]);
      drive_edge(3, sv[i], sd[i], sr[i], 1'b0);
    end
    drv_v[3] = 1'b0;
    drv_r[3] = 1'b0;
    checks++;
    if (popped.size() != 4) begin
      failures++; $display("FAIL bp_pop_len got=%0d exp=4", popped.size());
    end
    for (int k = 0; k < popped.size() && k < 4; k++) begin
      checks++;
      if (popped[k] !== exp_pop[k]) begin
        failures++; $display("FAIL bp_pop_order idx=%0d got=%h exp=%h", k, popped[k], exp_pop[k]);
      end
    end
  endtask

  task automatic test_flush();
    drive_edge(2, 1'b0, 32'h0, 1'b0, 1'b1);
    drive_edge(2, 1'b1, 32'h5, 1'b0, 1'b0);
    drive_edge(2, 1'b1, 32'h6, 1'b0, 1'b0);
    checks++;
    if (obs_c[2] !== 32'd2) begin
      failures++; $display("FAIL flush_pre_count got=%0d exp=2", obs_c[2]);
    end
    drive_edge(2, 1'b1, 32'h7, 1'b1, 1'b1);
    checks += 3;
    if (obs_c[2] !== 32'd0) begin
      failures++; $display("FAIL flush_count got=%0d exp=0", obs_c[2]);
    end
    if (obs_v[2] !== 1'b0) begin
      failures++; $display("FAIL flush_valid got=%b exp=0", obs_v[2]);
    end
    if (obs_ir[2] !== 1'b1) begin
      failures++; $display("FAIL flush_ready got=%b exp=1", obs_ir[2]);
    end
    drive_edge(2, 1'b1, 32'h8, 1'b0, 1'b0);
    drv_v[2] = 1'b0;
    checks += 2;
    if (obs_v[2] !== 1'b1) begin
      failures++; $display("FAIL flush_next_valid got=%b exp=1", obs_v[2]);
    end
    if (obs_d[2] !== 32'h8) begin
      failures++; $display("FAIL flush_next_data got=%h exp=8", obs_d[2]);
    end
    drive_edge(2, 1'b0, 32'h0, 1'b0, 1'b1);
  endtask

  task automatic test_depth1();
    for (int i = 0; i < 10; i++) begin
      checks += 2;
      if (obs_ir[1] !== ((i % 2) == 0)) begin
        failures++; $display("FAIL d1_ready cyc=%0d got=%b exp=%b", i, obs_ir[1], (i % 2) == 0);
      end
      if (obs_v[1] !== ((i % 2) == 1)) begin
        failures++; $display("FAIL d1_valid cyc=%0d got=%b exp=%b", i, obs_v[1], (i % 2) == 1);
      end
      if (obs_v[1] === 1'b1) begin
        checks++;
        if (obs_d[1] !== mhead(1)) begin
          failures++; $display("FAIL d1_data cyc=%0d got=%h exp=%h", i, obs_d[1], mhead(1));
        end
      end
      drive_edge(1, 1'b1, 32'h100 + 32'(i), 1'b1, 1'b0);
    end
    drive_edge(1, 1'b0, 32'h0, 1'b0, 1'b1);
  endtask

  task automatic test_random();
    for (int d = 1; d <= 3; d++) begin
      for (int i = 0; i < 40; i++) begin
        checks += 3;
        if (obs_c[d] !== 32'(msize(d))) begin
          failures++; $display("FAIL rand_count d=%0d cyc=%0d got=%0d exp=%0d", d, i, obs_c[d], msize(d));
        end
        if (obs_v[d] !== (msize(d) != 0) || obs_ir[d] !== (msize(d) != d)) begin
          failures++; $display("FAIL rand_flags d=%0d cyc=%0d got=v%b/r%b exp=v%b/r%b", d, i,
                               obs_v[d], obs_ir[d], msize(d) != 0, msize(d) != d);
        end
        if (obs_v[d] === 1'b1 && obs_d[d] !== mhead(d)) begin
          failures++; $display("FAIL rand_data d=%0d cyc=%0d got=%h exp=%h", d, i, obs_d[d], mhead(d));
        end
        drive_edge(d, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                   $urandom_range(0, 15) == 0);
      end
      drive_edge(d, 1'b0, 32'h0, 1'b0, 1'b1);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    for (int d = 1; d <= 3; d++) begin
      drv_v[d] = 1'b0;
      drv_d[d] = 32'h0;
      drv_r[d] = 1'b0;
      drv_f[d] = 1'b0;
    end
    model_clear();
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_depth1();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
